// File: rtl/procesador_pkg.sv
// Shared types and constants for the 128-bit vector pipeline memory stage.
package procesador_pkg;

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} mem_state_t;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   localparam int VEC_W  = 128;
   localparam int ADDR_W = 32;

   function automatic logic is_memop(input logic mem_write, input logic [1:0] result_src);
      return mem_write | (result_src == RES_MEM);
   endfunction

endpackage

// File: rtl/mem_req_fsm.sv
// Request/wait FSM for the data-memory handshake: request, stall, timeout and completion strobes.
module mem_req_fsm
   import procesador_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic start_i,
   input  logic mem_ack,
   output logic mem_req_o,
   output logic stall_o,
   output logic done_o,
   output logic abort_o
);

   localparam int               CNT_W       = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   mem_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             expired;

   assign expired = (cnt_q == TIMEOUT_VAL);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Everything is gated by rst so a reset mid-WAIT drops the request immediately.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_req_o = 1'b0;
      stall_o   = 1'b0;
      done_o    = 1'b0;
      abort_o   = 1'b0;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  mem_req_o = 1'b1;
                  if (mem_ack) begin
                     done_o = 1'b1;
                  end else begin
                     stall_o = 1'b1;
                     state_d = WAIT;
                     cnt_d   = CNT_ONE;
                  end
               end
            end
            WAIT: begin
               // An ack in the expiry cycle still completes the access.
               if (mem_ack) begin
                  mem_req_o = 1'b1;
                  done_o    = 1'b1;
                  state_d   = IDLE;
                  cnt_d     = '0;
               end else if (expired) begin
                  abort_o = 1'b1;
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  mem_req_o = 1'b1;
                  stall_o   = 1'b1;
                  cnt_d     = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/memory_cycle.sv
// Memory stage: alignment check, memory handshake via mem_req_fsm, and the W-stage pipeline register.
module memory_cycle
   import procesador_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int ALIGN_CHECK = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              RegWriteM,
   input  logic              MemWriteM,
   input  logic [1:0]        ResultSrcM,
   input  logic [4:0]        RdM,
   input  logic [ADDR_W-1:0] PCPlus4M,
   input  logic [VEC_W-1:0]  ALU_ResultM,
   input  logic [VEC_W-1:0]  WriteDataM,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [VEC_W-1:0]  mem_wdata,
   input  logic              mem_ack,
   input  logic [VEC_W-1:0]  mem_rdata,
   output logic              StallM,
   output logic              RegWriteW,
   output logic [1:0]        ResultSrcW,
   output logic [4:0]        RdW,
   output logic [ADDR_W-1:0] PCPlus4W,
   output logic [VEC_W-1:0]  ALU_ResultW,
   output logic [VEC_W-1:0]  ReadDataW,
   output logic              BusErrW
);

   logic memop, misaligned, start, done, abort;

   logic              reg_write_q, reg_write_d;
   logic [1:0]        result_src_q, result_src_d;
   logic [4:0]        rd_q, rd_d;
   logic [ADDR_W-1:0] pc_plus4_q, pc_plus4_d;
   logic [VEC_W-1:0]  alu_result_q, alu_result_d;
   logic [VEC_W-1:0]  read_data_q, read_data_d;
   logic              bus_err_q, bus_err_d;

   assign memop      = is_memop(MemWriteM, ResultSrcM);
   assign misaligned = (ALIGN_CHECK != 0) && memop && (ALU_ResultM[3:0] != 4'd0);
   assign start      = memop && !misaligned;

   mem_req_fsm #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start),
      .mem_ack   (mem_ack),
      .mem_req_o (mem_req),
      .stall_o   (StallM),
      .done_o    (done),
      .abort_o   (abort)
   );

   assign mem_we    = MemWriteM;
   assign mem_addr  = ALU_ResultM[ADDR_W-1:0];
   assign mem_wdata = WriteDataM;

   always_comb begin
      reg_write_d  = reg_write_q;
      result_src_d = result_src_q;
      rd_d         = rd_q;
      pc_plus4_d   = pc_plus4_q;
      alu_result_d = alu_result_q;
      read_data_d  = read_data_q;
      bus_err_d    = 1'b0;
      if (StallM) begin
         // Bubble: the instruction is still in M, so nothing may retire.
         reg_write_d  = 1'b0;
         result_src_d = RES_ALU;
      end else if (abort || misaligned) begin
         reg_write_d  = 1'b0;
         bus_err_d    = 1'b1;
         result_src_d = ResultSrcM;
         rd_d         = RdM;
         pc_plus4_d   = PCPlus4M;
         alu_result_d = ALU_ResultM;
      end else begin
         reg_write_d  = RegWriteM && !MemWriteM;
         result_src_d = ResultSrcM;
         rd_d         = RdM;
         pc_plus4_d   = PCPlus4M;
         alu_result_d = ALU_ResultM;
         if (done && !MemWriteM) begin
            read_data_d = mem_rdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         reg_write_q  <= 1'b0;
         result_src_q <= RES_ALU;
         rd_q         <= '0;
         pc_plus4_q   <= '0;
         alu_result_q <= '0;
         read_data_q  <= '0;
         bus_err_q    <= 1'b0;
      end else begin
         reg_write_q  <= reg_write_d;
         result_src_q <= result_src_d;
         rd_q         <= rd_d;
         pc_plus4_q   <= pc_plus4_d;
         alu_result_q <= alu_result_d;
         read_data_q  <= read_data_d;
         bus_err_q    <= bus_err_d;
      end
   end

   assign RegWriteW   = reg_write_q;
   assign ResultSrcW  = result_src_q;
   assign RdW         = rd_q;
   assign PCPlus4W    = pc_plus4_q;
   assign ALU_ResultW = alu_result_q;
   assign ReadDataW   = read_data_q;
   assign BusErrW     = bus_err_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Directed self-checking bench for memory_cycle.
module tb_memory_cycle;

   logic         clk = 1'b0;
   logic         rst;
   logic         RegWriteM, MemWriteM;
   logic [1:0]   ResultSrcM;
   logic [4:0]   RdM;
   logic [31:0]  PCPlus4M;
   logic [127:0] ALU_ResultM, WriteDataM;
   logic         mem_req, mem_we, mem_ack;
   logic [31:0]  mem_addr;
   logic [127:0] mem_wdata, mem_rdata;
   logic         StallM, RegWriteW, BusErrW;
   logic [1:0]   ResultSrcW;
   logic [4:0]   RdW;
   logic [31:0]  PCPlus4W;
   logic [127:0] ALU_ResultW, ReadDataW;

   int checks   = 0;
   int failures = 0;

   memory_cycle #(.MEM_TIMEOUT(4), .ALIGN_CHECK(1)) dut (
      .clk(clk), .rst(rst),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM),
      .PCPlus4M(PCPlus4M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .StallM(StallM),
      .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW), .PCPlus4W(PCPlus4W),
      .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .BusErrW(BusErrW)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      RegWriteM   = 1'b0;
      MemWriteM   = 1'b0;
      ResultSrcM  = 2'b00;
      RdM         = 5'd0;
      PCPlus4M    = 32'd0;
      ALU_ResultM = '0;
      WriteDataM  = '0;
      mem_ack     = 1'b0;
      mem_rdata   = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      idle_inputs();
      #1;
      chk("rst_req", mem_req, 1'b0);
      chk("rst_stall", StallM, 1'b0);
      tick();
      tick();
      chk("rst_regw", RegWriteW, 1'b0);
      chk("rst_rd", RdW, 5'd0);
      chk("rst_alu", ALU_ResultW, 128'h0);
      chk("rst_buserr", BusErrW, 1'b0);
      rst = 1'b0;

      // ALU op
      RegWriteM = 1'b1; RdM = 5'd5; ALU_ResultM = 128'hA5; PCPlus4M = 32'h10;
      #1;
      chk("alu_req", mem_req, 1'b0);
      chk("alu_stall", StallM, 1'b0);
      tick();
      chk("alu_regw", RegWriteW, 1'b1);
      chk("alu_rd", RdW, 5'd5);
      chk("alu_res", ALU_ResultW, 128'hA5);
      chk("alu_pc4", PCPlus4W, 32'h10);
      chk("alu_rdata_hold", ReadDataW, 128'h0);
      chk("alu_req2", mem_req, 1'b0);
      idle_inputs();

      // Zero-wait load
      ResultSrcM = 2'b01; RegWriteM = 1'b1; RdM = 5'd7; ALU_ResultM = 128'h100;
      mem_ack = 1'b1; mem_rdata = 128'hDEADBEEF;
      #1;
      chk("zw_req", mem_req, 1'b1);
      chk("zw_we", mem_we, 1'b0);
      chk("zw_addr", mem_addr, 32'h100);
      chk("zw_stall", StallM, 1'b0);
      tick();
      chk("zw_rdata", ReadDataW, 128'hDEADBEEF);
      chk("zw_src", ResultSrcW, 2'b01);
      chk("zw_regw", RegWriteW, 1'b1);
      chk("zw_rd", RdW, 5'd7);
      idle_inputs();
      #1;
      chk("zw_idle_after", mem_req, 1'b0);

      // 3-wait store (RegWriteM set to show stores never write back)
      MemWriteM = 1'b1; RegWriteM = 1'b1; RdM = 5'd3; ALU_ResultM = 128'h200; WriteDataM = 128'h1234;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("st_req", mem_req, 1'b1);
         chk("st_we", mem_we, 1'b1);
         chk("st_wdata", mem_wdata, 128'h1234);
         chk("st_addr", mem_addr, 32'h200);
         chk("st_stall", StallM, 1'b1);
         tick();
         chk("st_bubble_regw", RegWriteW, 1'b0);
         chk("st_bubble_src", ResultSrcW, 2'b00);
      end
      mem_ack = 1'b1;
      #1;
      chk("st_ack_req", mem_req, 1'b1);
      chk("st_ack_stall", StallM, 1'b0);
      tick();
      chk("st_ret_regw", RegWriteW, 1'b0);
      chk("st_ret_buserr", BusErrW, 1'b0);
      chk("st_ret_rd", RdW, 5'd3);
      chk("st_ret_rdata_hold", ReadDataW, 128'hDEADBEEF);
      idle_inputs();

      // Timeout: no ack
      ResultSrcM = 2'b01; RegWriteM = 1'b1; RdM = 5'd9; ALU_ResultM = 128'h300; mem_rdata = 128'hFFFF;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("to_req", mem_req, 1'b1);
         chk("to_stall", StallM, 1'b1);
         tick();
      end
      #1;
      chk("to_req_drop", mem_req, 1'b0);
      chk("to_stall_drop", StallM, 1'b0);
      tick();
      chk("to_buserr", BusErrW, 1'b1);
      chk("to_regw", RegWriteW, 1'b0);
      chk("to_rd", RdW, 5'd9);
      chk("to_rdata_hold", ReadDataW, 128'hDEADBEEF);
      idle_inputs();
      #1;
      chk("to_idle_req", mem_req, 1'b0);
      tick();
      chk("to_buserr_1cyc", BusErrW, 1'b0);

      // Ack in the expiry cycle wins over timeout
      ResultSrcM = 2'b01; RegWriteM = 1'b1; RdM = 5'd11; ALU_ResultM = 128'h400; mem_rdata = 128'h55;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("race_stall", StallM, 1'b1);
         tick();
      end
      mem_ack = 1'b1;
      #1;
      chk("race_req", mem_req, 1'b1);
      chk("race_stall_drop", StallM, 1'b0);
      tick();
      chk("race_rdata", ReadDataW, 128'h55);
      chk("race_buserr", BusErrW, 1'b0);
      chk("race_regw", RegWriteW, 1'b1);
      idle_inputs();

      // Misaligned load
      ResultSrcM = 2'b01; RegWriteM = 1'b1; RdM = 5'd4; ALU_ResultM = 128'h104;
      #1;
      chk("mis_req", mem_req, 1'b0);
      chk("mis_stall", StallM, 1'b0);
      tick();
      chk("mis_buserr", BusErrW, 1'b1);
      chk("mis_regw", RegWriteW, 1'b0);
      chk("mis_rd", RdW, 5'd4);
      idle_inputs();

      // Reset in the 2nd wait cycle
      ResultSrcM = 2'b01; RegWriteM = 1'b1; RdM = 5'd6; ALU_ResultM = 128'h500; PCPlus4M = 32'h44;
      tick();
      tick();
      #1;
      chk("rw_in_wait", StallM, 1'b1);
      rst = 1'b1;
      #1;
      chk("rw_req", mem_req, 1'b0);
      chk("rw_stall", StallM, 1'b0);
      tick();
      chk("rw_regw", RegWriteW, 1'b0);
      chk("rw_src", ResultSrcW, 2'b00);
      chk("rw_rd", RdW, 5'd0);
      chk("rw_pc4", PCPlus4W, 32'h0);
      chk("rw_alu", ALU_ResultW, 128'h0);
      chk("rw_rdata", ReadDataW, 128'h0);
      chk("rw_buserr", BusErrW, 1'b0);
      rst = 1'b0;
      idle_inputs();
      mem_ack = 1'b1; mem_rdata = 128'hBAD;
      #1;
      chk("rw_ack_req", mem_req, 1'b0);
      tick();
      chk("rw_ack_ignored", ReadDataW, 128'h0);
      chk("rw_ack_regw", RegWriteW, 1'b0);
      mem_ack = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
